// File: rtl/recebe_ascii_bcd_if.sv
//------------------------------------------------------------------------------
// Module : recebe_ascii_bcd_if
// Brief  : Serial line, enable and BCD result bundle of the ASCII-to-BCD receiver.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface recebe_ascii_bcd_if;
  logic       rx_serial;
  logic       habilita;
  logic [7:0] bcd;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    output rx_serial,
    output habilita,
    input  bcd,
    input  pronto,
    input  erro,
    input  db_estado
  );

  modport slave (
    input  rx_serial,
    input  habilita,
    output bcd,
    output pronto,
    output erro,
    output db_estado
  );
endinterface

`default_nettype wire

// File: rtl/recebe_ascii_bcd.sv
//------------------------------------------------------------------------------
// Module : recebe_ascii_bcd
// Brief  : 8N1 UART receiver that packs two ASCII decimal digits into one BCD
//          byte. Optional macro RECEBE_ASCII_BCD_TERMINADOR_EN requires a CR
//          after the units digit before the value is committed.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module recebe_ascii_bcd #(
  parameter int CICLOS_POR_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  recebe_ascii_bcd_if.slave bus
);

  localparam int             c_cnt_w    = (CICLOS_POR_BIT > 2) ? $clog2(CICLOS_POR_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_bit_fim  = c_cnt_w'(CICLOS_POR_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_meio_fim = c_cnt_w'((CICLOS_POR_BIT / 2) - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_um   = c_cnt_w'(1);
  localparam logic [7:0]     c_cr       = 8'h0D;
  localparam logic [7:0]     c_lf       = 8'h0A;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    INICIO = 2'd1,
    DADOS  = 2'd2,
    PARADA = 2'd3
  } uart_t;

  typedef enum logic [1:0] {
    ESPERA_DEZENA     = 2'd0,
    ESPERA_UNIDADE    = 2'd1,
    ESPERA_TERMINADOR = 2'd2
  } digito_t;

  // Line synchronizer; all three flops idle high so reset never fakes a start edge.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx_serial;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  uart_t              uart_q, uart_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               w_char_ok;
  logic               w_frame_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_q  <= OCIOSO;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      uart_q  <= uart_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    uart_d      = uart_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    w_char_ok   = 1'b0;
    w_frame_err = 1'b0;
    case (uart_q)
      OCIOSO: begin
        if (rx_prev_q && !rx_sync_q) begin
          uart_d = INICIO;
          cnt_d  = '0;
        end
      end
      INICIO: begin
        if (cnt_q == c_meio_fim) begin
          cnt_d  = '0;
          bit_d  = '0;
          // A line back high at mid start bit is a glitch, not a frame.
          uart_d = rx_sync_q ? OCIOSO : DADOS;
        end else begin
          cnt_d = cnt_q + c_cnt_um;
        end
      end
      DADOS: begin
        if (cnt_q == c_bit_fim) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            uart_d = PARADA;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_um;
        end
      end
      PARADA: begin
        if (cnt_q == c_bit_fim) begin
          cnt_d       = '0;
          uart_d      = OCIOSO;
          w_char_ok   = rx_sync_q;
          w_frame_err = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + c_cnt_um;
        end
      end
      default: begin
        uart_d = OCIOSO;
      end
    endcase
  end

  logic w_digito;
  logic w_crlf;

  assign w_digito = (shreg_q >= 8'h30) && (shreg_q <= 8'h39);
  assign w_crlf   = (shreg_q == c_cr) || (shreg_q == c_lf);

  digito_t    estado_q, estado_d;
  logic [3:0] dezena_q, dezena_d;
  logic [7:0] bcd_q, bcd_d;
  logic       pronto_q, pronto_d;
  logic       erro_q, erro_d;
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
  logic [3:0] unidade_q, unidade_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= ESPERA_DEZENA;
      dezena_q  <= '0;
      bcd_q     <= 8'h00;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
      unidade_q <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      dezena_q  <= dezena_d;
      bcd_q     <= bcd_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
      unidade_q <= unidade_d;
`endif
    end
  end

  always_comb begin
    estado_d  = estado_q;
    dezena_d  = dezena_q;
    bcd_d     = bcd_q;
    pronto_d  = 1'b0;
    erro_d    = 1'b0;
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
    unidade_d = unidade_q;
`endif
    if (!bus.habilita) begin
      estado_d = ESPERA_DEZENA;
    end else if (w_frame_err) begin
      erro_d   = 1'b1;
      estado_d = ESPERA_DEZENA;
    end else if (w_char_ok) begin
      case (estado_q)
        ESPERA_DEZENA: begin
          if (w_digito) begin
            dezena_d = shreg_q[3:0];
            estado_d = ESPERA_UNIDADE;
          end else if (!w_crlf) begin
            erro_d = 1'b1;
          end
        end
        ESPERA_UNIDADE: begin
          if (w_digito) begin
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
            unidade_d = shreg_q[3:0];
            estado_d  = ESPERA_TERMINADOR;
`else
            bcd_d    = {dezena_q, shreg_q[3:0]};
            pronto_d = 1'b1;
            estado_d = ESPERA_DEZENA;
`endif
          end else begin
            erro_d   = 1'b1;
            estado_d = ESPERA_DEZENA;
          end
        end
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
        ESPERA_TERMINADOR: begin
          if (shreg_q == c_cr) begin
            bcd_d    = {dezena_q, unidade_q};
            pronto_d = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
          estado_d = ESPERA_DEZENA;
        end
`endif
        default: begin
          estado_d = ESPERA_DEZENA;
        end
      endcase
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.pronto    = pronto_q;
  assign bus.erro      = erro_q;
  assign bus.db_estado = {2'b00, estado_q};

endmodule

`default_nettype wire

// File: tb/tb_recebe_ascii_bcd.sv
//------------------------------------------------------------------------------
// Module : tb_recebe_ascii_bcd
// Brief  : Scoreboard bench for recebe_ascii_bcd with a character-level model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_recebe_ascii_bcd;

  localparam int CPB = 16;
  localparam int P   = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #(P/2) clock = ~clock;

  recebe_ascii_bcd_if bus();

  recebe_ascii_bcd #(.CICLOS_POR_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit         is_pronto;
    logic [7:0] bcd;
    time        t_lo;
    time        t_hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model state: what the host has typed so far.
  bit         m_hab;
  bit         m_have_tens;
  int         m_tens;
  bit         m_await;
  int         m_pend;
  logic [7:0] m_bcd;

  logic [7:0] prev_bcd;
  bit         prev_pronto;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input bit ok, input time ts);
    exp_t e;
    e.is_pronto = ok;
    e.bcd       = m_bcd;
    e.t_lo      = ts + (CPB/2) * P;
    e.t_hi      = ts + (CPB/2 + 5) * P;
    exp_q.push_back(e);
  endtask

  task automatic model_char(input logic [7:0] c, input bit stop_ok, input time ts);
    int  v;
    bit  dig;
    v   = int'(c);
    dig = (v >= 48) && (v <= 57);
    if (!m_hab) return;
    if (!stop_ok) begin
      m_have_tens = 0;
      m_await     = 0;
      push_exp(1'b0, ts);
    end else if (m_await) begin
      m_await     = 0;
      m_have_tens = 0;
      if (v == 13) begin
        m_bcd = 8'(m_pend);
        push_exp(1'b1, ts);
      end else begin
        push_exp(1'b0, ts);
      end
    end else if (!m_have_tens) begin
      if (dig) begin
        m_tens      = v - 48;
        m_have_tens = 1;
      end else if (v != 13 && v != 10) begin
        push_exp(1'b0, ts);
      end
    end else begin
      m_have_tens = 0;
      if (dig) begin
`ifdef RECEBE_ASCII_BCD_TERMINADOR_EN
        m_pend  = m_tens * 16 + (v - 48);
        m_await = 1;
`else
        m_bcd = 8'(m_tens * 16 + (v - 48));
        push_exp(1'b1, ts);
`endif
      end else begin
        push_exp(1'b0, ts);
      end
    end
  endtask

  task automatic send_char(input logic [7:0] c, input bit stop_ok, input int gap);
    time ts;
    @(negedge clock);
    bus.rx_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      bus.rx_serial = c[i];
      repeat (CPB) @(negedge clock);
    end
    bus.rx_serial = stop_ok;
    ts = $time;
    model_char(c, stop_ok, ts);
    repeat (CPB) @(negedge clock);
    bus.rx_serial = 1'b1;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
    send_char(a, 1'b1, 2);
    send_char(b, 1'b1, 2);
    send_char(8'h0D, 1'b1, 2);
    repeat (2*CPB) @(negedge clock);
  endtask

  task automatic set_hab(input bit h);
    @(negedge clock);
    bus.habilita = h;
    m_hab        = h;
    if (!h) begin
      m_have_tens = 0;
      m_await     = 0;
    end
  endtask

  initial begin
    exp_t e;
    bus.rx_serial = 1'b1;
    bus.habilita  = 1'b1;
    m_hab = 1; m_have_tens = 0; m_tens = 0; m_await = 0; m_pend = 0; m_bcd = 8'h00;
    prev_bcd = 8'h00; prev_pronto = 0;

    fork
      begin : monitor
        forever begin
          @(negedge clock);
          if (!reset) begin
            prev_bcd    = 8'h00;
            prev_pronto = 0;
            continue;
          end
          if (bus.pronto || bus.erro) begin
            check("pulse_exclusive", 32'(bus.pronto & bus.erro), 32'd0);
            if (bus.pronto) check("pronto_width", 32'(prev_pronto), 32'd0);
            if (exp_q.size() == 0) begin
              check("unexpected_pulse", {30'd0, bus.pronto, bus.erro}, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("pulse_kind_pronto", 32'(bus.pronto), 32'(e.is_pronto));
              check("bcd_at_pulse", 32'(bus.bcd), 32'(e.bcd));
              check("pulse_latency", 32'(($time >= e.t_lo) && ($time <= e.t_hi)), 32'd1);
            end
          end
          if (bus.bcd !== prev_bcd) check("bcd_change_needs_pronto", 32'(bus.pronto), 32'd1);
          prev_bcd    = bus.bcd;
          prev_pronto = bus.pronto;
        end
      end
    join_none

    repeat (5) @(negedge clock);
    check("reset_bcd", 32'(bus.bcd), 32'h00);
    check("reset_pronto", 32'(bus.pronto), 32'd0);
    check("reset_erro", 32'(bus.erro), 32'd0);
    check("reset_db_estado", 32'(bus.db_estado), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Basic pair
    send_char(8'h34, 1'b1, 4);
    check("db_after_tens", 32'(bus.db_estado), 32'd1);
    send_char(8'h37, 1'b1, 2);
    send_char(8'h0D, 1'b1, 2);
    repeat (2*CPB) @(negedge clock);
    check("bcd_47", 32'(bus.bcd), 32'h47);

    // Non-digit units, then recovery
    send_char(8'h39, 1'b1, 2);
    send_char(8'h58, 1'b1, 2);
    repeat (2*CPB) @(negedge clock);
    check("bcd_kept_after_X", 32'(bus.bcd), 32'h47);
    send_pair(8'h30, 8'h35);
    check("bcd_05", 32'(bus.bcd), 32'h05);

    // Framing error, then recovery
    send_char(8'h32, 1'b0, 4);
    send_pair(8'h31, 8'h33);
    check("bcd_13", 32'(bus.bcd), 32'h13);

    // Short glitch while idle
    @(negedge clock);
    bus.rx_serial = 1'b0;
    repeat (4) @(negedge clock);
    bus.rx_serial = 1'b1;
    repeat (2*CPB) @(negedge clock);
    check("db_after_glitch", 32'(bus.db_estado), 32'd0);

    // Disabled traffic is dropped
    set_hab(1'b0);
    send_char(8'h38, 1'b1, 2);
    send_char(8'h38, 1'b1, 2);
    repeat (2*CPB) @(negedge clock);
    check("bcd_kept_while_disabled", 32'(bus.bcd), 32'h13);
    set_hab(1'b1);
    send_pair(8'h36, 8'h31);
    check("bcd_61", 32'(bus.bcd), 32'h61);

    // Reset in the middle of the units character
    send_char(8'h37, 1'b1, 2);
    @(negedge clock);
    bus.rx_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    bus.rx_serial = 1'b1;
    repeat (CPB) @(negedge clock);
    bus.rx_serial = 1'b0;
    repeat (CPB) @(negedge clock);
    bus.rx_serial = 1'b1;
    repeat (CPB/2) @(negedge clock);
    reset = 1'b0;
    m_have_tens = 0; m_await = 0; m_bcd = 8'h00;
    exp_q.delete();
    repeat (3) @(negedge clock);
    check("midreset_bcd", 32'(bus.bcd), 32'h00);
    check("midreset_pronto", 32'(bus.pronto), 32'd0);
    check("midreset_db_estado", 32'(bus.db_estado), 32'd0);
    reset = 1'b1;
    repeat (CPB) @(negedge clock);
    send_pair(8'h35, 8'h30);
    check("bcd_50", 32'(bus.bcd), 32'h50);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      int          r;
      logic [7:0]  ch;
      bit          ok;
      r  = int'($urandom_range(0, 99));
      ok = 1'b1;
      if (r < 60) begin
        ch = 8'(8'h30 + $urandom_range(0, 9));
      end else if (r < 70) begin
        ch = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
      end else if (r < 85) begin
        ch = 8'($urandom_range(0, 255));
      end else begin
        ch = 8'(8'h30 + $urandom_range(0, 9));
        ok = 1'b0;
      end
      send_char(ch, ok, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 99) < 8) set_hab(~m_hab);
    end
    if (!m_hab) set_hab(1'b1);

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
